// File: rtl/stream_arb_4_1.sv
// 4:1 valid/ready round-robin stream arbiter with a 1-entry registered output slice.
// Define STREAM_ARB_FIXED_PRIO_EN for a fixed-priority build (lowest index wins, no pointer).
module stream_arb_4_1 #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  output logic [3:0]   in_ready,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned IW   = 2;

  logic [IW-1:0] start_idx;
  logic [IW-1:0] cand;
  logic [IW-1:0] gnt_idx;
  logic          gnt_found;
  logic          free;
  logic          xfer_in;

  logic          valid_q, valid_d;
  logic [W-1:0]  data_q,  data_d;
  logic [IW-1:0] sel_q,   sel_d;

`ifdef STREAM_ARB_FIXED_PRIO_EN
  assign start_idx = IW'(0);
`else
  logic [IW-1:0] ptr_q, ptr_d;

  // Pointer advances past the winner only when a word is actually taken.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer_in) ptr_d = gnt_idx + IW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= IW'(0);
    else     ptr_q <= ptr_d;
  end

  assign start_idx = ptr_q;
`endif

  // First valid requester at or after start_idx, wrapping 3 -> 0.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = IW'(0);
    cand      = start_idx;
    for (int k = 0; k < NREQ; k++) begin
      cand = start_idx + IW'(k);
      if (!gnt_found && in_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign free = !valid_q || out_ready;

  always_comb begin
    in_ready = '0;
    if (!rst && free && gnt_found) in_ready[gnt_idx] = 1'b1;
  end

  assign xfer_in = |in_ready;

  // Slice next state: load on input transfer, drain on output-only transfer.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (xfer_in) begin
      valid_d = 1'b1;
      sel_d   = gnt_idx;
      case (gnt_idx)
        2'd0:    data_d = d0;
        2'd1:    data_d = d1;
        2'd2:    data_d = d2;
        default: data_d = d3;
      endcase
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= IW'(0);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule
